uart_tx_arb: RTL

Round-robin arbiter and sequencer that shares one uart_tx transmitter among NUM_REQ byte requesters.
- Accepts one byte at a time over a per-requester valid/ready handshake.
- Issues a single-cycle start pulse to the transmitter and holds the byte stable for the whole frame.
- Paces frames with a cycle counter, because the transmitter has no busy output.
- Runs entirely in the transmitter's bit-clock domain, on the same clock and reset as the transmitter.

---
 rtl/uart_tx_arb_if.sv | 40 ++++
 rtl/uart_tx_arb.sv | 129 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arb_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arb_if
// Handshake and transmitter bundle between NUM_REQ byte requesters, the
// round-robin arbiter, and the shared uart_tx transmitter.
//   i_req_valid [NUM_REQ]   per-requester byte valid (held until accepted)
//   i_req_data  [8*NUM_REQ] packed bytes, requester k at [8k+7:8k]
//   o_req_ready [NUM_REQ]   one-hot grant from the arbiter
//   o_tx_start              single-cycle start pulse to the transmitter
//   o_tx_data   [8]         byte to the transmitter, stable for the frame
//   o_busy                  arbiter is pacing a frame
// Modports: master = requester/transmitter side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic                 o_tx_start;
    logic [7:0]           o_tx_data;
    logic                 o_busy;

    modport master (
        output i_req_valid,
        output i_req_data,
        input  o_req_ready,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy
    );

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        output o_req_ready,
        output o_tx_start,
        output o_tx_data,
        output o_busy
    );
endinterface

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter/sequencer sharing one uart_tx among NUM_REQ requesters.
// Accepts one byte per frame, pulses start for one cycle, holds the byte for
// the frame and paces frames with a down-counter (the transmitter has no busy).
// Ports:
//   i_clk_tx        transmitter bit clock, rising edge
//   i_reset         asynchronous active-low reset
//   bus (slave)     requester handshake + transmitter outputs, see uart_tx_arb_if
//   o_owner         (UART_TX_ARB_OWNER_EN) index of last accepted requester
//   o_owner_valid   (UART_TX_ARB_OWNER_EN) equals o_busy
// Optional feature macro: UART_TX_ARB_OWNER_EN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready is the combinational round-robin grant; accept on valid
// FRAME | frame in flight; counter runs down, ready held low
// ---------------------------------------------------------------------------
module uart_tx_arb #(
    parameter  int NUM_REQ      = 4,
    parameter  int FRAME_CYCLES = 11,
    localparam int OWNER_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk_tx,
    input  logic               i_reset,
    uart_tx_arb_if.slave       bus
`ifdef UART_TX_ARB_OWNER_EN
    ,
    output logic [OWNER_W-1:0] o_owner,
    output logic               o_owner_valid
`endif
);
    localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
    // Accept edge plus the edge where the counter reads zero account for two
    // of the FRAME_CYCLES edges between accepts.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 2);

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    state_t             r_state;
    logic [OWNER_W-1:0] r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_busy;

    logic               w_found;
    logic [OWNER_W-1:0] w_winner;
    logic [OWNER_W-1:0] w_next_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [7:0]         w_winner_data;

    // Search from the pointer upward with wrap; first asserted valid wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && bus.i_req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx[OWNER_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (r_state == IDLE && w_found) w_grant[w_winner] = 1'b1;
    end

    assign w_winner_data = bus.i_req_data[{w_winner, 3'b000} +: 8];
    assign w_next_ptr    = (w_winner == OWNER_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge i_clk_tx or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
`ifdef UART_TX_ARB_OWNER_EN
            o_owner    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_tx_data  <= w_winner_data;
                        r_tx_start <= 1'b1;
                        r_ptr      <= w_next_ptr;
                        r_cnt      <= CNT_LOAD;
                        r_busy     <= 1'b1;
                        r_state    <= FRAME;
`ifdef UART_TX_ARB_OWNER_EN
                        o_owner    <= w_winner;
`endif
                    end
                end
                FRAME: begin
                    r_tx_start <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req_ready = w_grant;
    assign bus.o_tx_start  = r_tx_start;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_busy      = r_busy;

`ifdef UART_TX_ARB_OWNER_EN
    assign o_owner_valid = r_busy;
`endif

endmodule
